// File: rtl/rr_onehot_grant.sv
// Round-robin arbiter with a registered one-hot grant held until ack.
// Define RR_TIMEOUT_EN to add forced release after TIMEOUT unacked grant cycles.
module rr_onehot_grant #(
   parameter int NUM_REQ = 8,
   parameter int TIMEOUT = 16
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [NUM_REQ-1:0]         req,
   input  logic                       gnt_ack,
   output logic [NUM_REQ-1:0]         gnt,
   output logic                       gnt_valid,
   output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
   output logic                       timeout
);
   localparam int IW = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 32 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_chk
      $error("rr_onehot_grant: parameter out of range");
   end

   typedef enum logic {IDLE, GRANT} state_t;

   state_t             state, state_nxt;
   logic [IW-1:0]      ptr, ptr_nxt, idx_nxt, sel_idx;
   logic [NUM_REQ-1:0] gnt_nxt;
   logic               sel_found, force_rel;

   // NUM_REQ need not be a power of two, so wrap explicitly.
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      return IW'(s);
   endfunction

   // Scan downward so the lowest offset from ptr is the last (winning) assignment.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req[wrap_add(ptr, k)]) begin
            sel_found = 1'b1;
            sel_idx   = wrap_add(ptr, k);
         end
      end
   end

   always_comb begin
      state_nxt = state;
      gnt_nxt   = gnt;
      idx_nxt   = gnt_idx;
      ptr_nxt   = ptr;
      unique case (state)
         IDLE: begin
            if (sel_found) begin
               state_nxt = GRANT;
               gnt_nxt   = NUM_REQ'(1) << sel_idx;
               idx_nxt   = sel_idx;
            end
         end
         GRANT: begin
            if (gnt_ack || force_rel) begin
               state_nxt = IDLE;
               gnt_nxt   = '0;
               idx_nxt   = '0;
               ptr_nxt   = wrap_add(gnt_idx, 1);
            end
         end
         default: begin
            state_nxt = IDLE;
            gnt_nxt   = '0;
            idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state   <= IDLE;
         ptr     <= '0;
         gnt     <= '0;
         gnt_idx <= '0;
      end else begin
         state   <= state_nxt;
         ptr     <= ptr_nxt;
         gnt     <= gnt_nxt;
         gnt_idx <= idx_nxt;
      end
   end

   assign gnt_valid = (state == GRANT);

`ifdef RR_TIMEOUT_EN
   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic [CW-1:0] cnt;

   // An ack in the expiry cycle wins, so no pulse in that case.
   assign force_rel = (state == GRANT) && !gnt_ack && (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= force_rel;
         if (state != GRANT)
            cnt <= '0;
         else if (!gnt_ack && !force_rel)
            cnt <= cnt + 1'b1;
      end
   end
`else
   assign force_rel = 1'b0;
   assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_onehot_grant.sv
// Bench for rr_onehot_grant: vector table plus hand sequences, checked via a scoreboard queue.
module tb_rr_onehot_grant;
   logic       clk;
   logic       resetn;
   logic [7:0] req;
   logic       gnt_ack;
   logic [7:0] gnt;
   logic       gnt_valid;
   logic [2:0] gnt_idx;
   logic       timeout;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] req;
      logic       ack;
      logic [7:0] gnt;
      logic       vld;
      logic [2:0] idx;
      logic       to;
   } vec_t;

   vec_t tbl[$];
   vec_t exp_q[$];

   rr_onehot_grant #(.NUM_REQ(8), .TIMEOUT(4)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .req       (req),
      .gnt_ack   (gnt_ack),
      .gnt       (gnt),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, " gnt"},       32'(gnt),       32'h0);
      check({tag, " gnt_valid"}, 32'(gnt_valid), 32'h0);
      check({tag, " gnt_idx"},   32'(gnt_idx),   32'h0);
      check({tag, " timeout"},   32'(timeout),   32'h0);
   endtask

   function automatic vec_t mk(input logic [7:0] r, input logic a, input logic [7:0] g,
                               input logic v, input logic [2:0] i, input logic t);
      vec_t x;
      x.req = r; x.ack = a; x.gnt = g; x.vld = v; x.idx = i; x.to = t;
      return x;
   endfunction

   // Inputs applied at a falling edge; expected outputs appear after the next rising edge.
   task automatic step(input vec_t x);
      @(negedge clk);
      req     = x.req;
      gnt_ack = x.ack;
      exp_q.push_back(x);
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn  = 1'b0;
      req     = '0;
      gnt_ack = 1'b0;
      @(negedge clk);
      resetn  = 1'b1;
   endtask

   always @(posedge clk) begin
      vec_t e;
      #1;
      if (resetn && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("gnt",       32'(gnt),       32'(e.gnt));
         check("gnt_valid", 32'(gnt_valid), 32'(e.vld));
         check("gnt_idx",   32'(gnt_idx),   32'(e.idx));
         check("timeout",   32'(timeout),   32'(e.to));
         check("onehot0",   32'($onehot0(gnt)), 32'h1);
      end
   end

   initial begin
      resetn  = 1'b0;
      req     = '0;
      gnt_ack = 1'b0;

      // idle, full rotation, wrap past an earlier grant
      for (int i = 0; i < 5; i++) tbl.push_back(mk(8'h00, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0));
      for (int i = 0; i < 9; i++) begin
         tbl.push_back(mk(8'hFF, 1'b0, 8'(1 << (i % 8)), 1'b1, 3'(i % 8), 1'b0));
         tbl.push_back(mk(8'hFF, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
      end

      repeat (3) @(negedge clk);
      check_zero("reset");
      resetn = 1'b1;

      foreach (tbl[i]) step(tbl[i]);

      // ptr back to 0; 8'hA0 picks 5, then 8'h21 must wrap to 0
      do_reset();
      step(mk(8'hA0, 1'b0, 8'h20, 1'b1, 3'd5, 1'b0));
      step(mk(8'hA0, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
      step(mk(8'h21, 1'b0, 8'h01, 1'b1, 3'd0, 1'b0));
      step(mk(8'h21, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));

`ifndef RR_TIMEOUT_EN
      // owner drops req[3] but holds the grant; ptr then lands on 4
      step(mk(8'h08, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0));
      for (int i = 0; i < 4; i++) step(mk(8'h00, 1'b0, 8'h08, 1'b1, 3'd3, 1'b0));
      step(mk(8'h00, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
      step(mk(8'h19, 1'b0, 8'h10, 1'b1, 3'd4, 1'b0));
      step(mk(8'h19, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
`endif

      // reset mid-grant clears outputs at once and restarts ptr at 0
      step(mk(8'h04, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0));
      @(negedge clk);
      check("pre-reset gnt", 32'(gnt), 32'h04);
      #2 resetn = 1'b0;
      #1 check_zero("async reset");
      @(negedge clk);
      resetn = 1'b1;
      step(mk(8'h24, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0));
      step(mk(8'h24, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));

`ifdef RR_TIMEOUT_EN
      // unacked grant to 1 is forced off 4 cycles later; next grant moves past 1
      do_reset();
      step(mk(8'h02, 1'b0, 8'h02, 1'b1, 3'd1, 1'b0));
      for (int i = 0; i < 3; i++) step(mk(8'h02, 1'b0, 8'h02, 1'b1, 3'd1, 1'b0));
      step(mk(8'h06, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1));
      step(mk(8'h06, 1'b0, 8'h04, 1'b1, 3'd2, 1'b0));
      step(mk(8'h06, 1'b1, 8'h00, 1'b0, 3'd0, 1'b0));
`endif

      @(negedge clk);
      req     = '0;
      gnt_ack = 1'b0;
      repeat (2) @(negedge clk);
      check("scoreboard drained", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
